// File: rtl/gshare_pkg.sv
// Shared types for the gshare prediction/resolution path.
// Default widths, resolver FSM states, in-flight entry layout, GHR repair helper.
package gshare_pkg;

    localparam int IDX_W_DEF = 4;
    localparam int GHR_W_DEF = 4;

    typedef enum logic {
        RUN,
        FLUSH
    } state_e;

    typedef struct packed {
        logic [IDX_W_DEF-1:0] index;
        logic                 taken;
        logic [GHR_W_DEF-1:0] ghr;
    } pend_entry_t;

    // Corrected history: pre-branch history shifted by the real outcome.
    function automatic logic [GHR_W_DEF-1:0] ghr_restore_f(
        input logic [GHR_W_DEF-1:0] ghr,
        input logic                 taken
    );
        return {ghr[GHR_W_DEF-2:0], taken};
    endfunction

endpackage

// File: rtl/gshare_pend_fifo.sv
// In-order FIFO of in-flight predictions awaiting resolution.
// Clear has priority over push and pop; callers qualify push/pop.
module gshare_pend_fifo
    import gshare_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  pend_entry_t                wdata,
    output pend_entry_t                rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CBW   = PTR_W + 1;

    pend_entry_t      mem_q [DEPTH];
    pend_entry_t      mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CBW-1:0]   cnt_q, cnt_d;

    assign rdata = mem_q[rd_q];
    assign full  = (cnt_q == CBW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

    // Next pointer/count/storage; pointers wrap naturally at DEPTH.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = wdata;
                wr_d        = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            cnt_d = cnt_q + CBW'(push) - CBW'(pop);
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gshare_resolver.sv
// Resolution end of the gshare predictor: in-order compare, PHT training, GHR repair.
// Optional GSHARE_RES_STATS_EN adds saturating hit/miss counters.
module gshare_resolver
    import gshare_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF,
    parameter int GHR_W = GHR_W_DEF,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pred_valid,
    output logic                     pred_ready,
    input  logic [IDX_W-1:0]         pred_index,
    input  logic                     pred_taken,
    input  logic [GHR_W-1:0]         pred_ghr,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     upd_valid,
    output logic [IDX_W-1:0]         upd_index,
    output logic                     upd_taken,
    output logic                     mispredict,
    output logic [GHR_W-1:0]         ghr_restore,
    output logic [$clog2(DEPTH):0]   pending,
    output logic                     res_orphan,
    output logic [CNT_W-1:0]         hit_cnt,
    output logic [CNT_W-1:0]         miss_cnt
);

    state_e            state_q, state_d;
    pend_entry_t       push_entry, head;
    logic              full, empty;
    logic              push, pop, miss, orphan_evt;
    logic              upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0]  upd_index_q, upd_index_d;
    logic              upd_taken_q, upd_taken_d;
    logic              mispredict_q, mispredict_d;
    logic [GHR_W-1:0]  ghr_restore_q, ghr_restore_d;
    logic              orphan_q, orphan_d;

    // No full-bypass: a same-cycle pop never frees a slot for a push.
    assign pred_ready = (state_q == RUN) && !full;
    assign push_entry = '{index: pred_index, taken: pred_taken, ghr: pred_ghr};

    // Resolve the head; a miss squashes the queue and any same-cycle push.
    always_comb begin
        pop        = res_valid && !empty && (state_q == RUN);
        miss       = pop && (head.taken != res_taken);
        push       = pred_valid && pred_ready && !miss;
        orphan_evt = res_valid && !pop;
    end

    gshare_pend_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .clear (miss),
        .wdata (push_entry),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (pending)
    );

    // FSM: one FLUSH cycle after every misprediction.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (miss) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Registered training / repair outputs and sticky orphan flag.
    always_comb begin
        upd_valid_d   = pop;
        upd_index_d   = pop ? head.index : upd_index_q;
        upd_taken_d   = pop ? res_taken : upd_taken_q;
        mispredict_d  = miss;
        ghr_restore_d = ghr_restore_q;
        if (miss) begin
            ghr_restore_d = ghr_restore_f(head.ghr, res_taken);
        end
        orphan_d = orphan_q | orphan_evt;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= RUN;
            upd_valid_q   <= 1'b0;
            upd_index_q   <= '0;
            upd_taken_q   <= 1'b0;
            mispredict_q  <= 1'b0;
            ghr_restore_q <= '0;
            orphan_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            upd_valid_q   <= upd_valid_d;
            upd_index_q   <= upd_index_d;
            upd_taken_q   <= upd_taken_d;
            mispredict_q  <= mispredict_d;
            ghr_restore_q <= ghr_restore_d;
            orphan_q      <= orphan_d;
        end
    end

    assign upd_valid   = upd_valid_q;
    assign upd_index   = upd_index_q;
    assign upd_taken   = upd_taken_q;
    assign mispredict  = mispredict_q;
    assign ghr_restore = ghr_restore_q;
    assign res_orphan  = orphan_q;

`ifdef GSHARE_RES_STATS_EN
    logic             hit;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

    // Saturating statistics counters.
    always_comb begin
        hit        = pop && !miss;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (hit && (hit_cnt_q != '1)) begin
            hit_cnt_d = hit_cnt_q + 1'b1;
        end
        if (miss && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + 1'b1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
`else
    assign hit_cnt  = '0;
    assign miss_cnt = '0;
`endif

endmodule

// File: tb/tb_gshare_resolver.sv
// Scoreboard bench for gshare_resolver against a queue-based reference model.
module tb_gshare_resolver;

    localparam int IDX_W = 4;
    localparam int GHR_W = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 3;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             pred_valid = 1'b0;
    logic             pred_ready;
    logic [IDX_W-1:0] pred_index = '0;
    logic             pred_taken = 1'b0;
    logic [GHR_W-1:0] pred_ghr = '0;
    logic             res_valid = 1'b0;
    logic             res_taken = 1'b0;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_index;
    logic             upd_taken;
    logic             mispredict;
    logic [GHR_W-1:0] ghr_restore;
    logic [2:0]       pending;
    logic             res_orphan;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    gshare_resolver #(
        .IDX_W (IDX_W),
        .GHR_W (GHR_W),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pred_valid  (pred_valid),
        .pred_ready  (pred_ready),
        .pred_index  (pred_index),
        .pred_taken  (pred_taken),
        .pred_ghr    (pred_ghr),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .upd_valid   (upd_valid),
        .upd_index   (upd_index),
        .upd_taken   (upd_taken),
        .mispredict  (mispredict),
        .ghr_restore (ghr_restore),
        .pending     (pending),
        .res_orphan  (res_orphan),
        .hit_cnt     (hit_cnt),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit tk;
        int ghr;
    } ent_t;

    typedef struct {
        int due;
        int idx;
        bit tk;
        bit mis;
        int ghr;
    } exp_t;

    ent_t m_q[$];
    exp_t exp_q[$];
    bit   m_flush;
    bit   m_orph;
    int   m_hit;
    int   m_miss;
    int   m_last;
    int   cyc;
    int   n_chk;
    int   n_pass;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int exp_hit();
`ifdef GSHARE_RES_STATS_EN
        return m_hit;
`else
        return 0;
`endif
    endfunction

    function automatic int exp_miss();
`ifdef GSHARE_RES_STATS_EN
        return m_miss;
`else
        return 0;
`endif
    endfunction

    // Monitor: pops an expectation whenever a training pulse appears.
    always @(negedge clk) begin
        if (reset) begin
            if (upd_valid) begin
                if (exp_q.size() == 0) begin
                    chk("upd_spurious", upd_valid, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("upd_latency", cyc, e.due);
                    chk("upd_index", upd_index, e.idx);
                    chk("upd_taken", upd_taken, e.tk);
                    chk("mispredict", mispredict, e.mis);
                    if (e.mis) chk("ghr_restore_pulse", ghr_restore, e.ghr);
                end
            end else begin
                if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                    chk("upd_missing", upd_valid, 1);
                    void'(exp_q.pop_front());
                end
                if (mispredict) chk("mispredict_alone", mispredict, 0);
            end
        end
    end

    function automatic bit m_ready();
        return !m_flush && (m_q.size() < DEPTH);
    endfunction

    // One cycle: check current outputs, drive inputs, advance model.
    task automatic step(input bit pv, input int idx, input bit pt,
                        input int ghr, input bit rv, input bit rt);
        bit   rdy;
        bit   miss;
        ent_t e;
        exp_t x;
        rdy = m_ready();
        chk("pending", pending, m_q.size());
        chk("pred_ready", pred_ready, rdy);
        chk("res_orphan", res_orphan, m_orph);
        chk("hit_cnt", hit_cnt, exp_hit());
        chk("miss_cnt", miss_cnt, exp_miss());
        chk("ghr_restore_hold", ghr_restore, m_last);
        pred_valid = pv;
        pred_index = IDX_W'(idx);
        pred_taken = pt;
        pred_ghr   = GHR_W'(ghr);
        res_valid  = rv;
        res_taken  = rt;
        miss = 1'b0;
        if (rv && (m_flush || m_q.size() == 0)) begin
            m_orph = 1'b1;
        end else if (rv) begin
            e = m_q.pop_front();
            miss = (e.tk != rt);
            x.due = cyc + 1;
            x.idx = e.idx;
            x.tk  = rt;
            x.mis = miss;
            x.ghr = ((e.ghr * 2) + int'(rt)) % 16;
            exp_q.push_back(x);
            if (miss) begin
                m_q.delete();
                m_last = x.ghr;
                if (m_miss < CMAX) m_miss++;
            end else if (m_hit < CMAX) begin
                m_hit++;
            end
        end
        if (pv && rdy && !miss) begin
            e.idx = idx;
            e.tk  = pt;
            e.ghr = ghr;
            m_q.push_back(e);
        end
        m_flush = miss;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset asserted between edges, released on a falling edge.
    task automatic do_reset();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_pending", pending, 0);
        chk("rst_upd_valid", upd_valid, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_ghr_restore", ghr_restore, 0);
        chk("rst_orphan", res_orphan, 0);
        chk("rst_hit_cnt", hit_cnt, 0);
        chk("rst_miss_cnt", miss_cnt, 0);
        m_q.delete();
        exp_q.delete();
        m_flush = 0;
        m_orph  = 0;
        m_hit   = 0;
        m_miss  = 0;
        m_last  = 0;
        @(negedge clk);
        reset = 1'b1;
        #1 chk("rst_pred_ready", pred_ready, 1);
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        cyc    = 0;
        @(negedge clk);
        do_reset();

        // Single taken hit at index 5.
        step(1, 5, 1, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1);
        idle();

        // Not-taken prediction resolved taken with two younger entries.
        step(1, 3, 0, 4'b1010, 0, 0);
        step(1, 7, 1, 1, 0, 0);
        step(1, 8, 1, 2, 0, 0);
        step(1, 9, 1, 3, 1, 1);
        idle();
        idle();

        // Fill the queue, then push and resolve together while full.
        step(1, 1, 1, 1, 0, 0);
        step(1, 2, 0, 2, 0, 0);
        step(1, 4, 1, 3, 0, 0);
        step(1, 6, 1, 4, 0, 0);
        step(1, 9, 1, 5, 1, 1);
        idle();

        // Reset while three entries are pending.
        do_reset();

        // Resolution against an empty queue.
        step(0, 0, 0, 0, 1, 0);
        idle();
        idle();

        // Hit-counter saturation.
        for (int i = 0; i < CMAX + 3; i++) begin
            step(1, i % 16, 1, i % 16, 0, 0);
            step(0, 0, 0, 0, 1, 1);
        end
        idle();

        // Randomized traffic with occasional mid-stream resets.
        for (int i = 0; i < 600; i++) begin
            if (i % 200 == 199) begin
                do_reset();
            end else begin
                step(($urandom % 4) != 0, int'($urandom % 16),
                     ($urandom % 4) != 0, int'($urandom % 16),
                     ($urandom % 3) == 0, ($urandom % 4) != 0);
            end
        end

        idle();
        idle();
        chk("exp_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
